// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - BIN over WIDTH cycles with borrow out and signed overflow
module serial_subtractor #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] D,
  output logic             BA,
  output logic             ovf,
  output logic             valid
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] sa, sb, res, nres;
  logic [CNT_W-1:0] cnt;
  logic br, d, bo, last;
  always_comb begin
    d     = sa[0] ^ sb[0] ^ br;
    bo    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    nres  = {d, res[WIDTH-1:1]};
    last  = cnt == CNT_W'(WIDTH - 1);
    ready = state == IDLE;
    busy  = ~ready;
  end
  // on the last bit sa[0]/sb[0] are the captured operand MSBs and d is the result MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      D     <= '0;
      BA    <= 1'b0;
      ovf   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= state == DONE;
      case (state)
        IDLE: if (start) begin
          sa    <= A;
          sb    <= B;
          br    <= BIN;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= nres;
          br  <= bo;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            state <= DONE;
            D     <= nres;
            BA    <= bo;
            ovf   <= (sa[0] ^ sb[0]) & (sa[0] ^ d);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
